// File: rtl/uart_pkg.sv
// Shared types and clocking constants for the 3 Mbps UART receiver.
// Optional macro UART_RX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;

    localparam int UART_CLK_HZ       = 120_000_000;
    localparam int UART_BAUD         = 3_000_000;
    localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic       rx_m;
    logic [1:0] fill;
    logic       hi_seen;

    // hi_seen only tracks rx_s once real line data has reached it, so a line
    // already low when reset releases never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            fill    <= 2'b00;
            hi_seen <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            fill    <= {fill[0], 1'b1};
            hi_seen <= fill[1] & rx_s;
        end
    end

    assign rx_fall = hi_seen & ~rx_s;

endmodule

// File: rtl/uart_rx_3m.sv
// UART receiver, 8N1 at CLKS_PER_BIT clocks per bit with valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 (even parity checked before the stop bit).
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | timing to mid start bit, rejects glitches
// DATA   | sampling 8 data bits mid-bit, LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, byte complete or framing error
module uart_rx_3m
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_s;
    logic             rx_fall;
    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             byte_done;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx_fall) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        par_bad   <= (^shreg) ^ rx_s;
                        frame_err <= (^shreg) ^ rx_s;
                        state     <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            byte_done <= ~par_bad;
`else
                            byte_done <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A byte landing in the same cycle as a transfer replaces the old one.
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_3m.md
UART_RX_3M -- requirements
Module: uart_rx_3m

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 40, meaning clock cycles per UART bit (120 MHz / 3 Mbps); legal range 8..1023.
REQ-002 SHALL have port clk  input  1  the single clock, 120 MHz from the PLL output; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port rx_data  output  8  received byte, LSB first on the line.
REQ-006 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: byte completed while rx_valid high and rx_ready low.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, STOP (plus PARITY, see Configuration).
REQ-012 IDLE -> START on rx_s falling edge; bit counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2-1, rx_s low -> DATA with counter reset; rx_s high -> IDLE (glitch rejected, no error).
REQ-014 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), shift in LSB first; after 8th sample -> STOP (or PARITY).
REQ-015 STOP: at mid-bit sample, high -> byte complete; low -> frame_err pulse, byte discarded; both -> IDLE the next cycle (half-bit resync margin).
REQ-016 Byte complete: rx_data and rx_valid update one clk after the stop-bit sample.
REQ-017 Handshake: transfer when rx_valid && rx_ready; rx_valid deasserts the next cycle unless a new byte completes in the same cycle, in which case rx_valid stays high with the new data.
REQ-018 Byte completing while rx_valid && !rx_ready: overrun pulse, new byte dropped, rx_data unchanged.
REQ-019 rx_data SHALL be stable whenever rx_valid is high.
REQ-020 Counter width SHALL be $clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rx_valid/frame_err/overrun 0.
REQ-022 Reset mid-frame SHALL abandon the frame; after release, the receiver waits for a fresh falling edge (a line already low is not a start).

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: PARITY state after DATA samples an even-parity bit; mismatch -> frame_err pulse, byte discarded, then STOP is still sampled.
REQ-024 Macro undefined: 8N1 only, PARITY state and logic absent, DATA -> STOP directly.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum typedef, UART_CLK_HZ = 120_000_000, UART_BAUD = 3_000_000, and the default CLKS_PER_BIT derived from them.
REQ-026 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer and falling-edge detect.

Verification
REQ-027 Byte 8'hA5 at 40 clk/bit, rx_ready held 1 -> rx_valid one cycle, rx_data = 8'hA5, no errors.
REQ-028 Low glitch of 10 clk in IDLE -> no rx_valid, no frame_err, state back to IDLE.
REQ-029 Byte 8'h3C with stop bit low -> frame_err one pulse, rx_valid stays 0.
REQ-030 Bytes 8'h11 then 8'h22 back-to-back, rx_ready 0 -> rx_valid high, rx_data = 8'h11, overrun one pulse at the second byte.
REQ-031 rst_n pulsed low during bit 4 of 8'hFF, rx held low through release -> no byte until the next idle-high-then-falling edge; next byte 8'h5A received correctly.
REQ-032 UART_RX_PARITY_EN defined, 8'h07 with parity bit 0 (wrong) -> frame_err pulse, no rx_valid; with parity 1 -> rx_data = 8'h07.
